// File: rtl/german_param_system.sv
// german_param_system: German cache-coherence protocol model with one rule fired per clock.
// Define GERMAN_INV_CHECK_EN to build the CtrlProp/DataProp invariant monitor.
module german_param_system #(
    parameter int NUM_NODES  = 3,
    parameter int DATA_WIDTH = 2,
    parameter int NODE_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_valid,
    input  logic [3:0]                io_rule,
    input  logic [NODE_W-1:0]         io_node,
    input  logic [DATA_WIDTH-1:0]     io_data,
    output logic                      io_fired,
    output logic [2:0]                io_cur_cmd,
    output logic                      io_ex_gntd,
    output logic [DATA_WIDTH-1:0]     io_mem_data,
    output logic [DATA_WIDTH-1:0]     io_aux_data,
    output logic [2*NUM_NODES-1:0]    io_cache_state,
    output logic                      io_ctrl_ok,
    output logic                      io_data_ok,
    output logic                      io_inv_fail
);
    localparam logic [2:0] CMD_EMPTY  = 3'd0;
    localparam logic [2:0] CMD_REQS   = 3'd1;
    localparam logic [2:0] CMD_REQE   = 3'd2;
    localparam logic [2:0] CMD_INV    = 3'd3;
    localparam logic [2:0] CMD_INVACK = 3'd4;
    localparam logic [2:0] CMD_GNTS   = 3'd5;
    localparam logic [2:0] CMD_GNTE   = 3'd6;
    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;

    logic [2*NUM_NODES-1:0] cache_state;
    logic [DATA_WIDTH-1:0]  cache_data [NUM_NODES];
    logic [2:0]             ch1_cmd    [NUM_NODES];
    logic [2:0]             ch2_cmd    [NUM_NODES];
    logic [2:0]             ch3_cmd    [NUM_NODES];
    logic [DATA_WIDTH-1:0]  ch2_data   [NUM_NODES];
    logic [DATA_WIDTH-1:0]  ch3_data   [NUM_NODES];
    logic [NUM_NODES-1:0]   inv_set, shr_set;
    logic [2:0]             cur_cmd;
    logic [NODE_W-1:0]      cur_ptr;
    logic                   ex_gntd, fired;
    logic [DATA_WIDTH-1:0]  mem_data, aux_data;

    logic              node_ok, guard, fire;
    logic [NODE_W-1:0] sel;
    logic [1:0]        st;

    // Out-of-range nodes are steered to node 0 for reads but can never fire.
    assign node_ok = 32'(io_node) < NUM_NODES;
    assign sel     = node_ok ? io_node : '0;
    assign st      = cache_state[2*sel +: 2];

    always_comb begin
        guard = 1'b0;
        case (io_rule)
            4'd0:  guard = ch1_cmd[sel] == CMD_EMPTY && st == ST_I;
            4'd1:  guard = ch1_cmd[sel] == CMD_EMPTY && (st == ST_I || st == ST_S);
            4'd2:  guard = cur_cmd == CMD_EMPTY && ch1_cmd[sel] == CMD_REQS;
            4'd3:  guard = cur_cmd == CMD_EMPTY && ch1_cmd[sel] == CMD_REQE;
            4'd4:  guard = ch2_cmd[sel] == CMD_EMPTY && inv_set[sel] &&
                           (cur_cmd == CMD_REQE || (cur_cmd == CMD_REQS && ex_gntd));
            4'd5:  guard = ch2_cmd[sel] == CMD_INV && ch3_cmd[sel] == CMD_EMPTY;
            4'd6:  guard = ch3_cmd[sel] == CMD_INVACK && cur_cmd != CMD_EMPTY;
            4'd7:  guard = cur_cmd == CMD_REQS && cur_ptr == sel && ch2_cmd[sel] == CMD_EMPTY && !ex_gntd;
            4'd8:  guard = cur_cmd == CMD_REQE && cur_ptr == sel && ch2_cmd[sel] == CMD_EMPTY && !ex_gntd &&
                           shr_set == '0;
            4'd9:  guard = ch2_cmd[sel] == CMD_GNTS;
            4'd10: guard = ch2_cmd[sel] == CMD_GNTE;
            4'd11: guard = st == ST_E;
            default: guard = 1'b0;
        endcase
    end

    assign fire = io_valid && node_ok && guard;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cache_state <= '0;
            inv_set     <= '0;
            shr_set     <= '0;
            cur_cmd     <= CMD_EMPTY;
            cur_ptr     <= '0;
            ex_gntd     <= 1'b0;
            mem_data    <= '0;
            aux_data    <= '0;
            fired       <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                cache_data[i] <= '0;
                ch1_cmd[i]    <= CMD_EMPTY;
                ch2_cmd[i]    <= CMD_EMPTY;
                ch3_cmd[i]    <= CMD_EMPTY;
                ch2_data[i]   <= '0;
                ch3_data[i]   <= '0;
            end
        end else begin
            fired <= fire;
            if (fire) begin
                case (io_rule)
                    4'd0: ch1_cmd[sel] <= CMD_REQS;
                    4'd1: ch1_cmd[sel] <= CMD_REQE;
                    4'd2, 4'd3: begin
                        cur_cmd      <= ch1_cmd[sel];
                        cur_ptr      <= sel;
                        ch1_cmd[sel] <= CMD_EMPTY;
                        inv_set      <= shr_set;
                    end
                    4'd4: begin
                        ch2_cmd[sel] <= CMD_INV;
                        inv_set[sel] <= 1'b0;
                    end
                    4'd5: begin
                        ch2_cmd[sel]            <= CMD_EMPTY;
                        ch3_cmd[sel]            <= CMD_INVACK;
                        ch3_data[sel]           <= (st == ST_E) ? cache_data[sel] : ch3_data[sel];
                        cache_state[2*sel +: 2] <= ST_I;
                        cache_data[sel]         <= '0;
                    end
                    4'd6: begin
                        ch3_cmd[sel] <= CMD_EMPTY;
                        shr_set[sel] <= 1'b0;
                        ex_gntd      <= 1'b0;
                        mem_data     <= ex_gntd ? ch3_data[sel] : mem_data;
                    end
                    4'd7, 4'd8: begin
                        ch2_cmd[sel]  <= (io_rule == 4'd7) ? CMD_GNTS : CMD_GNTE;
                        ch2_data[sel] <= mem_data;
                        shr_set[sel]  <= 1'b1;
                        ex_gntd       <= ex_gntd || io_rule == 4'd8;
                        cur_cmd       <= CMD_EMPTY;
                    end
                    4'd9, 4'd10: begin
                        cache_state[2*sel +: 2] <= (io_rule == 4'd9) ? ST_S : ST_E;
                        cache_data[sel]         <= ch2_data[sel];
                        ch2_cmd[sel]            <= CMD_EMPTY;
                    end
                    4'd11: begin
                        cache_data[sel] <= io_data;
                        aux_data        <= io_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io_fired       = fired;
    assign io_cur_cmd     = cur_cmd;
    assign io_ex_gntd     = ex_gntd;
    assign io_mem_data    = mem_data;
    assign io_aux_data    = aux_data;
    assign io_cache_state = cache_state;

`ifdef GERMAN_INV_CHECK_EN
    logic ctrl_ok, data_ok, inv_fail;

    always_comb begin
        ctrl_ok = 1'b1;
        data_ok = ex_gntd || mem_data == aux_data;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (cache_state[2*i +: 2] != ST_I && cache_data[i] != aux_data) data_ok = 1'b0;
            for (int j = 0; j < NUM_NODES; j++) begin
                if (i != j && cache_state[2*i +: 2] == ST_E && cache_state[2*j +: 2] != ST_I) ctrl_ok = 1'b0;
                if (i != j && cache_state[2*i +: 2] == ST_S && cache_state[2*j +: 2] == ST_E) ctrl_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) inv_fail <= 1'b0;
        else        inv_fail <= inv_fail || !ctrl_ok || !data_ok;
    end

    assign io_ctrl_ok  = ctrl_ok;
    assign io_data_ok  = data_ok;
    assign io_inv_fail = inv_fail;
`else
    assign io_ctrl_ok  = 1'b1;
    assign io_data_ok  = 1'b1;
    assign io_inv_fail = 1'b0;
`endif
endmodule

// File: tb/tb_german_param_system.sv
// tb_german_param_system: scoreboarded rule-sequence bench for german_param_system (NUM_NODES=3, DATA_WIDTH=2).
module tb_german_param_system;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_valid = 1'b0;
    logic [3:0] io_rule = '0;
    logic [1:0] io_node = '0;
    logic [1:0] io_data = '0;
    logic       io_fired, io_ex_gntd, io_ctrl_ok, io_data_ok, io_inv_fail;
    logic [2:0] io_cur_cmd;
    logic [1:0] io_mem_data, io_aux_data;
    logic [5:0] io_cache_state;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    german_param_system #(.NUM_NODES(3), .DATA_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .io_valid(io_valid), .io_rule(io_rule),
        .io_node(io_node), .io_data(io_data), .io_fired(io_fired),
        .io_cur_cmd(io_cur_cmd), .io_ex_gntd(io_ex_gntd), .io_mem_data(io_mem_data),
        .io_aux_data(io_aux_data), .io_cache_state(io_cache_state),
        .io_ctrl_ok(io_ctrl_ok), .io_data_ok(io_data_ok), .io_inv_fail(io_inv_fail)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Drive one request for a cycle; the expected io_fired is queued now and popped after the edge.
    task automatic fire_rule(input logic [3:0] r, input logic [1:0] n, input logic [1:0] d, input bit exp);
        bit e;
        @(negedge clock);
        io_valid = 1'b1; io_rule = r; io_node = n; io_data = d;
        exp_q.push_back(exp);
        @(negedge clock);
        io_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (io_fired !== e) begin
            errors++;
            $display("FAIL fired rule%0d node%0d: got %b expected %b", r, n, io_fired, e);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        io_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({io_fired, io_cur_cmd, io_ex_gntd, io_mem_data, io_aux_data, io_cache_state} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0",
                     {io_fired, io_cur_cmd, io_ex_gntd, io_mem_data, io_aux_data, io_cache_state});
        end
        io_valid = 1'b1; io_rule = 4'd1; io_node = 2'd0;
        @(negedge clock);
        checks++;
        if (io_fired !== 1'b0) begin
            errors++;
            $display("FAIL fired_in_reset: got %b expected 0", io_fired);
        end
        io_valid = 1'b0;
        reset = 1'b1;
        fire_rule(4'd3, 2'd0, 2'd0, 1'b0);
        checks++;
        if (io_cur_cmd !== 3'd0) begin
            errors++;
            $display("FAIL discarded_req: cur_cmd got %0d expected 0", io_cur_cmd);
        end
    endtask

    task automatic test_exclusive_grant();
        fire_rule(4'd1, 2'd1, 2'd0, 1'b1);
        fire_rule(4'd3, 2'd1, 2'd0, 1'b1);
        checks++;
        if (io_cur_cmd !== 3'd2) begin
            errors++;
            $display("FAIL cur_cmd_reqe: got %0d expected 2", io_cur_cmd);
        end
        fire_rule(4'd8, 2'd1, 2'd0, 1'b1);
        fire_rule(4'd10, 2'd1, 2'd0, 1'b1);
        checks++;
        if (io_cache_state !== 6'b001000 || io_ex_gntd !== 1'b1 || io_cur_cmd !== 3'd0) begin
            errors++;
            $display("FAIL excl_grant: state %b exg %b cur %0d expected 001000 1 0",
                     io_cache_state, io_ex_gntd, io_cur_cmd);
        end
    endtask

    task automatic test_invalidate();
        fire_rule(4'd11, 2'd1, 2'b11, 1'b1);
        checks++;
        if (io_aux_data !== 2'b11) begin
            errors++;
            $display("FAIL store_aux: got %b expected 11", io_aux_data);
        end
        fire_rule(4'd0, 2'd0, 2'd0, 1'b1);
        fire_rule(4'd2, 2'd0, 2'd0, 1'b1);
        fire_rule(4'd4, 2'd1, 2'd0, 1'b1);
        fire_rule(4'd5, 2'd1, 2'd0, 1'b1);
        checks++;
        if (io_cache_state !== 6'b000000) begin
            errors++;
            $display("FAIL inv_ack_state: got %b expected 000000", io_cache_state);
        end
        fire_rule(4'd6, 2'd1, 2'd0, 1'b1);
        checks++;
        if (io_mem_data !== 2'b11 || io_ex_gntd !== 1'b0 || io_cur_cmd !== 3'd1) begin
            errors++;
            $display("FAIL writeback: mem %b exg %b cur %0d expected 11 0 1",
                     io_mem_data, io_ex_gntd, io_cur_cmd);
        end
    endtask

    task automatic test_no_fire();
        fire_rule(4'd11, 2'd0, 2'b01, 1'b0);
        fire_rule(4'd11, 2'd3, 2'b01, 1'b0);
        fire_rule(4'd12, 2'd0, 2'b01, 1'b0);
        fire_rule(4'd15, 2'd1, 2'b01, 1'b0);
        checks++;
        if ({io_cur_cmd, io_ex_gntd, io_mem_data, io_aux_data, io_cache_state} !== {3'd1, 1'b0, 2'b11, 2'b11, 6'b0}) begin
            errors++;
            $display("FAIL no_fire_regs: got %h expected %h",
                     {io_cur_cmd, io_ex_gntd, io_mem_data, io_aux_data, io_cache_state},
                     {3'd1, 1'b0, 2'b11, 2'b11, 6'b0});
        end
        @(negedge clock);
        io_valid = 1'b0; io_rule = 4'd7; io_node = 2'd0;
        @(negedge clock);
        checks++;
        if (io_fired !== 1'b0 || io_cur_cmd !== 3'd1) begin
            errors++;
            $display("FAIL valid_low: fired %b cur %0d expected 0 1", io_fired, io_cur_cmd);
        end
    endtask

    task automatic test_shared_grant();
        fire_rule(4'd7, 2'd1, 2'd0, 1'b0);
        fire_rule(4'd7, 2'd0, 2'd0, 1'b1);
        fire_rule(4'd9, 2'd0, 2'd0, 1'b1);
        checks++;
        if (io_cache_state !== 6'b000001 || io_cur_cmd !== 3'd0 || io_ctrl_ok !== 1'b1 || io_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL shared_grant: state %b cur %0d ok %b%b expected 000001 0 11",
                     io_cache_state, io_cur_cmd, io_ctrl_ok, io_data_ok);
        end
    endtask

    task automatic test_mid_reset();
        fire_rule(4'd1, 2'd0, 2'd0, 1'b1);
        fire_rule(4'd3, 2'd0, 2'd0, 1'b1);
        checks++;
        if (io_cur_cmd !== 3'd2 || io_fired !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: cur %0d fired %b expected 2 1", io_cur_cmd, io_fired);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({io_fired, io_cur_cmd, io_ex_gntd, io_mem_data, io_aux_data, io_cache_state} !== 15'd0 ||
            io_inv_fail !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {io_fired, io_cur_cmd, io_ex_gntd, io_mem_data, io_aux_data, io_cache_state});
        end
        @(negedge clock);
        reset = 1'b1;
        fire_rule(4'd1, 2'd2, 2'd0, 1'b1);
    endtask

    task automatic test_invariant();
`ifdef GERMAN_INV_CHECK_EN
        @(negedge clock);
        force dut.cache_state = 6'b000110;
        #1;
        checks++;
        if (io_ctrl_ok !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_prop: got %b expected 0", io_ctrl_ok);
        end
        @(negedge clock);
        release dut.cache_state;
        checks++;
        if (io_inv_fail !== 1'b1) begin
            errors++;
            $display("FAIL inv_fail_set: got %b expected 1", io_inv_fail);
        end
        idle();
        idle();
        checks++;
        if (io_inv_fail !== 1'b1) begin
            errors++;
            $display("FAIL inv_fail_sticky: got %b expected 1", io_inv_fail);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (io_inv_fail !== 1'b0) begin
            errors++;
            $display("FAIL inv_fail_clear: got %b expected 0", io_inv_fail);
        end
        reset = 1'b1;
`else
        idle();
        checks++;
        if (io_ctrl_ok !== 1'b1 || io_data_ok !== 1'b1 || io_inv_fail !== 1'b0) begin
            errors++;
            $display("FAIL monitor_off: got %b%b%b expected 110", io_ctrl_ok, io_data_ok, io_inv_fail);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_exclusive_grant();
        test_invalidate();
        test_no_fire();
        test_shared_grant();
        test_mid_reset();
        test_invariant();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
